pattern_stream_gen: RTL and testbench
=====================================

Name: pattern_stream_gen

Overview:
Upstream pixel source for the FIFO/display pipeline. Produces an 8-bit grayscale pixel stream in raster order, one full frame at a time, over a valid/ready handshake. Downstream logic colours the stream and the FIFO buffers it. Generates selectable test patterns, with a frame counter for animated patterns. Pattern changes take effect only at frame boundaries.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
CHECKER_LOG, 5, log2 of checkerboard square size (32 px)

Ports:
pixel_clk  input  1  pixel clock, all logic on rising edge
rst  input  1  synchronous active-high reset
mode_sel  input  2  requested pattern mode
mode_load  input  1  one-cycle pulse; captures mode_sel as pending mode
pixel_stream_data  output  8  current pixel value
pixel_stream_valid  output  1  pixel_stream_data is valid
pixel_stream_ready  input  1  downstream accepts the pixel this cycle
frame_start  output  1  high while the presented pixel is (0,0)
frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Clock/reset: one clock (pixel_clk); synchronous, active-high reset (rst).
- Reset values:
  - x=0, y=0, frame_count=0.
  - active mode=0, pending mode=0, pending flag=0.
  - pixel_stream_valid=0.
  - pixel_stream_data=0 and frame_start=0, forced while in reset.
- First cycle after rst deasserts: valid=1, presenting pixel (0,0).
- Transfer occurs when valid && ready on a rising edge.
- While valid && !ready, data, valid and frame_start hold stable.
- No combinational path from ready to valid or data.
- Data and frame_start are pure functions of registered state: x, y, active mode, frame_count.
- Counter advance on each transfer:
  - x++.
  - If x==H_ACTIVE-1: x<=0 and y++.
  - If additionally y==V_ACTIVE-1: y<=0 and frame_count<=frame_count+1 (8-bit wrap).
- x and y are 10-bit, unsigned.
- Pattern modes:
  - 0: horizontal gradient, data = x[9:2].
  - 1: vertical gradient, data = y[9:2].
  - 2: checkerboard, data = ((x>>CHECKER_LOG)^(y>>CHECKER_LOG))[0] ? 8'hFF : 8'h00.
  - 3: scrolling ramp, data = (x + frame_count)[7:0].
- Mode update:
  - mode_load sets pending mode=mode_sel and pending flag=1; a later load overwrites the pending mode.
  - On the transfer of the last pixel of a frame (x=H_ACTIVE-1, y=V_ACTIVE-1) with pending flag set: active mode<=pending mode, flag<=0.
  - If mode_load coincides with that final transfer, the new mode_sel value is applied directly.
- Mid-frame rules: a frame never mixes modes; frame_count never changes mid-frame.
- Reset mid-frame: next cycle returns to x=y=0 and mode 0; any pending mode is discarded.

Optional Feature:
PATTERN_GEN_LINE_GAP_EN
- Defined:
  - After the transfer of the last pixel of each line (x=H_ACTIVE-1), valid drops to 0 for exactly one cycle.
  - Valid then returns to 1, presenting x=0 of the next line.
  - This includes the frame wrap.
  - Exercises downstream handling of producer bubbles.
- Undefined: valid stays continuously high after reset, apart from backpressure holds.

Test Plan:
1. Reset release, ready=1 -> valid=1, data=8'h00, frame_start=1 on first cycle; frame_start=0 from the next cycle onward.
2. Mode 0, ready=1 for 801 transfers -> data 0,0,0,0,1,...; x=799 gives 8'd199; transfer 801 is (0,1) with data 0.
3. Backpressure at x=10 (data 2): ready=0 for 5 cycles -> valid=1 and data=2 held all 5 cycles; x=11 presented after the next transfer.
4. mode_sel=2 with mode_load pulse at pixel 1000 of frame 0 -> rest of frame 0 is still gradient; frame 1: (0,0)=00, (32,0)=FF, (32,32)=00, (0,32)=FF; frame_count=1.
5. Mode 3 after 2 frames -> (0,0)=8'd2, (255,0)=8'd1; after 256 completed frames, frame_count wraps to 0.
6. rst asserted at (400,300) in mode 2 with a pending mode 1 -> one cycle later: valid=0, x=y=0, mode 0, pending discarded; then (0,0)=8'h00. With PATTERN_GEN_LINE_GAP_EN: exactly one valid=0 cycle after each x=799 transfer.

Source files
------------

// File: rtl/pattern_stream_gen.sv
// Raster-order 8-bit test-pattern source over valid/ready; mode changes land only on frame boundaries.
// Optional PATTERN_GEN_LINE_GAP_EN inserts a one-cycle valid bubble after every line.
module pattern_stream_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int CHECKER_LOG = 5
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    output logic [7:0] pixel_stream_data,
    output logic       pixel_stream_valid,
    input  logic       pixel_stream_ready,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        MODE_HGRAD   = 2'd0,
        MODE_VGRAD   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_e;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fcount_q, fcount_d;
    mode_e      mode_q, mode_d;
    mode_e      pend_mode_q, pend_mode_d;
    logic       pend_q, pend_d;
    logic       valid_q, valid_d;

    logic       xfer;
    logic       line_end;
    logic       frame_end;
    logic [7:0] pix;

    assign xfer      = valid_q && pixel_stream_ready;
    assign line_end  = (x_q == X_LAST);
    assign frame_end = line_end && (y_q == Y_LAST);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        fcount_d    = fcount_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;

        if (mode_load) begin
            pend_mode_d = mode_e'(mode_sel);
            pend_d      = 1'b1;
        end

        if (xfer) begin
            if (line_end) begin
                x_d = '0;
                if (frame_end) begin
                    y_d      = '0;
                    fcount_d = fcount_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end

            // A load in the same cycle as the final transfer wins over the older pending value.
            if (frame_end) begin
                if (mode_load) begin
                    mode_d = mode_e'(mode_sel);
                end else if (pend_q) begin
                    mode_d = pend_mode_q;
                end
                pend_d = 1'b0;
            end
        end

`ifdef PATTERN_GEN_LINE_GAP_EN
        valid_d = !(xfer && line_end);
`else
        valid_d = 1'b1;
`endif
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            fcount_q    <= '0;
            mode_q      <= MODE_HGRAD;
            pend_mode_q <= MODE_HGRAD;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            fcount_q    <= fcount_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        pix = 8'h00;
        case (mode_q)
            MODE_HGRAD:   pix = x_q[9:2];
            MODE_VGRAD:   pix = y_q[9:2];
            MODE_CHECKER: pix = (x_q[CHECKER_LOG] ^ y_q[CHECKER_LOG]) ? 8'hFF : 8'h00;
            MODE_SCROLL:  pix = x_q[7:0] + fcount_q;
            default:      pix = 8'h00;
        endcase
    end

    // Outputs depend only on registered state; rst merely masks them while held.
    assign pixel_stream_data  = rst ? 8'h00 : pix;
    assign pixel_stream_valid = valid_q;
    assign frame_start        = !rst && valid_q && (x_q == '0) && (y_q == '0);
    assign frame_count        = fcount_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Self-checking bench for pattern_stream_gen on a reduced raster, using a pixel-index reference model.
module tb_pattern_stream_gen;

    localparam int H  = 24;
    localparam int V  = 5;
    localparam int CL = 2;
    localparam int HV = H * V;
`ifdef PATTERN_GEN_LINE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode_sel = 2'd0;
    logic       mode_load = 1'b0;
    logic [7:0] pixel_stream_data;
    logic       pixel_stream_valid;
    logic       pixel_stream_ready = 1'b1;
    logic       frame_start;
    logic [7:0] frame_count;

    int checks = 0;
    int failures = 0;

    // Reference model: n = pixels transferred since reset; everything else derives from it.
    int         n = 0;
    logic [1:0] m_mode = 2'd0;
    logic [1:0] m_pmode = 2'd0;
    bit         m_pend = 1'b0;
    bit         m_valid = 1'b0;

    pattern_stream_gen #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .CHECKER_LOG(CL)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .mode_sel(mode_sel),
        .mode_load(mode_load),
        .pixel_stream_data(pixel_stream_data),
        .pixel_stream_valid(pixel_stream_valid),
        .pixel_stream_ready(pixel_stream_ready),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic int mx();
        return n % H;
    endfunction
    function automatic int my();
        return (n / H) % V;
    endfunction
    function automatic logic [7:0] exp_fc();
        return 8'((n / HV) % 256);
    endfunction
    function automatic logic exp_fs();
        return m_valid && ((n % HV) == 0);
    endfunction
    function automatic logic [7:0] exp_data();
        int x, y;
        x = mx();
        y = my();
        case (m_mode)
            2'd0:    return 8'(x / 4);
            2'd1:    return 8'(y / 4);
            2'd2:    return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'((x + int'(exp_fc())) % 256);
        endcase
    endfunction

    // One clock: inputs set before, model advanced from the rules, returns at the next negedge.
    task automatic tick();
        bit xf, ll, lf;
        xf = m_valid && pixel_stream_ready;
        ll = (mx() == H - 1);
        lf = ll && (my() == V - 1);
        @(posedge pixel_clk);
        if (rst) begin
            n = 0; m_mode = 2'd0; m_pend = 1'b0; m_valid = 1'b0;
        end else begin
            if (mode_load) begin
                m_pmode = mode_sel;
                m_pend  = 1'b1;
            end
            if (xf && lf) begin
                if (m_pend) m_mode = m_pmode;
                m_pend = 1'b0;
            end
            if (xf) n++;
            m_valid = GAP ? !(xf && ll) : 1'b1;
        end
        @(negedge pixel_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pixel_stream_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({pixel_stream_valid, pixel_stream_data, frame_start} !== {1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold got v=%0b d=%0h fs=%0b want v=0 d=00 fs=0",
                     pixel_stream_valid, pixel_stream_data, frame_start);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL reset_first got v=%0b d=%0h fs=%0b fc=%0d want v=1 d=00 fs=1 fc=0",
                     pixel_stream_valid, pixel_stream_data, frame_start, frame_count);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_fs_drop got fs=%0b want 0", frame_start);
        end
        $display("test_reset done");
    endtask

    task automatic test_gradient();
        pixel_stream_ready = 1'b1;
        for (int i = 0; i < H + 2; i++) begin
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()}) begin
                failures++;
                $display("FAIL gradient n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc());
            end
            tick();
        end
        $display("test_gradient done");
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int guard;
        pixel_stream_ready = 1'b1;
        guard = 0;
        while (!(m_valid && mx() == 10) && guard < 4 * H) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 4 * H) begin
            failures++;
            $display("FAIL bp_reach got timeout want x=10");
        end
        held = exp_data();
        pixel_stream_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({pixel_stream_valid, pixel_stream_data} !== {1'b1, held}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%0b d=%0h want v=1 d=%0h",
                         i, pixel_stream_valid, pixel_stream_data, held);
            end
        end
        pixel_stream_ready = 1'b1;
        tick();
        checks++;
        if ({pixel_stream_valid, pixel_stream_data} !== {1'b1, exp_data()} || mx() != 11) begin
            failures++;
            $display("FAIL bp_resume got v=%0b d=%0h want v=1 d=%0h (x=%0d)",
                     pixel_stream_valid, pixel_stream_data, exp_data(), mx());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_mode_switch();
        int guard, target;
        pixel_stream_ready = 1'b1;
        guard = 0;
        while (!(m_valid && (n % HV) == 2 * H + 3) && guard < 2 * HV + 4 * V) begin
            tick();
            guard++;
        end
        mode_sel  = 2'd2;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        mode_sel  = 2'($urandom_range(3));
        target = n / HV + 2;
        guard = 0;
        while (n / HV < target && guard < 6 * HV) begin
            pixel_stream_ready = ($urandom_range(99) < 75);
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()}) begin
                failures++;
                $display("FAIL mode_switch n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc());
            end
            tick();
            guard++;
        end
        checks++;
        if (guard >= 6 * HV) begin
            failures++;
            $display("FAIL mode_switch_timeout got n=%0d want frame %0d", n, target);
        end
        $display("test_mode_switch done");
    endtask

    task automatic test_final_load();
        int guard;
        pixel_stream_ready = 1'b1;
        mode_sel  = 2'd1;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        guard = 0;
        while (!(m_valid && (n % HV) == HV - 1) && guard < 2 * HV) begin
            tick();
            guard++;
        end
        mode_sel  = 2'd3;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        mode_sel  = 2'd0;
        for (int i = 0; i < H + 3; i++) begin
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()} || m_mode != 2'd3) begin
                failures++;
                $display("FAIL final_load n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d mode=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc(), m_mode);
            end
            tick();
        end
        $display("test_final_load done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pixel_stream_ready = ($urandom_range(99) < 70);
            mode_load = ($urandom_range(99) < 3);
            mode_sel  = 2'($urandom_range(3));
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()}) begin
                failures++;
                $display("FAIL random n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc());
            end
            tick();
        end
        mode_load = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_wrap();
        int target, guard;
        bit wrapped;
        pixel_stream_ready = 1'b1;
        mode_sel  = 2'd3;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        target  = n / HV + 258;
        guard   = 0;
        wrapped = 1'b0;
        while (n / HV < target && guard < 300 * (HV + V)) begin
            if (n / HV >= 256 && frame_count == 8'd0) wrapped = 1'b1;
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()}) begin
                failures++;
                $display("FAIL wrap n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc());
            end
            tick();
            guard++;
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("FAIL wrap_seen got no fc=0 after 256 frames want wrap");
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_midframe();
        int guard;
        pixel_stream_ready = 1'b1;
        mode_sel  = 2'd2;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        guard = 0;
        while (!(m_valid && (n % HV) == 0) && guard < 2 * HV) begin
            tick();
            guard++;
        end
        mode_sel  = 2'd1;
        mode_load = 1'b1;
        tick();
        mode_load = 1'b0;
        while (!(m_valid && mx() == H / 2 && my() == V / 2) && guard < 4 * HV) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({pixel_stream_valid, pixel_stream_data, frame_start} !== {1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid got v=%0b d=%0h fs=%0b want v=0 d=00 fs=0",
                     pixel_stream_valid, pixel_stream_data, frame_start);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL rst_mid_first got v=%0b d=%0h fs=%0b fc=%0d want v=1 d=00 fs=1 fc=0",
                     pixel_stream_valid, pixel_stream_data, frame_start, frame_count);
        end
        // Two full frames in mode 0 prove the discarded pending mode never lands.
        for (int i = 0; i < 2 * (HV + V) + 3; i++) begin
            checks++;
            if ({pixel_stream_valid, pixel_stream_data, frame_start, frame_count} !==
                {m_valid, exp_data(), exp_fs(), exp_fc()} || m_mode != 2'd0) begin
                failures++;
                $display("FAIL rst_mid_run n=%0d got v=%0b d=%0h fs=%0b fc=%0d want v=%0b d=%0h fs=%0b fc=%0d",
                         n, pixel_stream_valid, pixel_stream_data, frame_start, frame_count,
                         m_valid, exp_data(), exp_fs(), exp_fc());
            end
            tick();
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        @(negedge pixel_clk);
        test_reset();
        test_gradient();
        test_backpressure();
        test_mode_switch();
        test_final_load();
        test_random();
        test_wrap();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
